// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch port and the MW data port.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin tie-break (default: data-first priority).

module mem_port_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic              cancelled_q, cancelled_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              busy_q, busy_d;
`ifdef MEM_ARB_RR_EN
  grant_t            last_grant_q, last_grant_d;
`endif

  logic if_elig;
  logic d_elig;
  logic pick_d;
  logic cancel_hit;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cancelled_d = cancelled_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif

    // A port in its own done cycle is still holding req for the finished access.
    if_elig = if_req && !if_done_q && !if_cancel;
    d_elig  = d_req && !d_done_q;
`ifdef MEM_ARB_RR_EN
    pick_d  = d_elig && (!if_elig || (last_grant_q == GRANT_I));
`else
    pick_d  = d_elig;
`endif
    cancel_hit = if_cancel && (grant_q == GRANT_I);

    case (state_q)
      ST_IDLE: begin
        if (if_elig || d_elig) begin
          state_d     = ST_ISSUE;
          grant_d     = pick_d ? GRANT_D : GRANT_I;
          cancelled_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_d && d_we;
          mem_addr_d  = pick_d ? d_addr : if_addr;
          mem_wdata_d = pick_d ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
          last_grant_d = pick_d ? GRANT_D : GRANT_I;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (cancel_hit) cancelled_d = 1'b1;
      end
      ST_WAIT: begin
        if (cancel_hit) cancelled_d = 1'b1;
        // The memory cannot abort, so a flushed fetch still waits here and just drops its data.
        if (mem_ready) begin
          state_d = ST_IDLE;
          if (grant_q == GRANT_D) begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end else if (!(cancelled_q || if_cancel)) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_D;
      cancelled_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= GRANT_D;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cancelled_q <= cancelled_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then random traffic against a transaction-level model.
// Honours MEM_ARB_RR_EN the same way the design does when predicting tie-breaks.

module tb_mem_port_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_cancel (if_cancel),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // Behavioural memory contents; unwritten words return an address-derived pattern.
  logic [31:0] mem_arr [logic [29:0]];

  // Transaction-level model: one outstanding access at most, plus predicted outputs.
  bit          m_busy;
  bit          m_issue;
  bit          m_is_d;
  bit          m_store;
  bit          m_cancel;
  bit          m_last_d;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  bit          e_mem_en, e_busy, e_if_done, e_d_done, e_mem_we;
  logic [29:0] e_mem_addr;
  logic [31:0] e_mem_wdata, e_if_rdata, e_d_rdata;

  int ready_cnt;
  int next_lat;
  bit auto_mem;
  bit stray_en;
  bit if_drop;
  bit d_drop;

  function automatic logic [31:0] mem_read(input logic [29:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {a, 2'b10} ^ 32'h5A3C_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate();
    bit n_if_done;
    bit n_d_done;
    bit eli;
    bit eld;
    bit win_d;
    n_if_done = 1'b0;
    n_d_done  = 1'b0;
    if (reset) begin
      m_busy = 0; m_issue = 0; m_cancel = 0; m_last_d = 1;
      e_mem_addr = '0; e_mem_we = 0; e_mem_wdata = '0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else if (!m_busy) begin
      eli = if_req && !e_if_done && !if_cancel;
      eld = d_req && !e_d_done;
      if (eli || eld) begin
`ifdef MEM_ARB_RR_EN
        win_d = eld && (!eli || !m_last_d);
`else
        win_d = eld;
`endif
        m_busy = 1; m_issue = 1; m_cancel = 0;
        m_is_d = win_d; m_last_d = win_d;
        m_store = win_d && d_we;
        m_addr  = win_d ? d_addr : if_addr;
        m_wdata = d_wdata;
        e_mem_addr = m_addr;
        e_mem_we   = m_store;
        if (win_d) e_mem_wdata = d_wdata;
      end
    end else if (m_issue) begin
      m_issue = 0;
      if (if_cancel && !m_is_d) m_cancel = 1;
    end else begin
      if (if_cancel && !m_is_d) m_cancel = 1;
      if (mem_ready) begin
        if (m_is_d) begin
          n_d_done = 1;
          if (m_store) mem_arr[m_addr] = m_wdata;
          else e_d_rdata = mem_read(m_addr);
        end else if (!m_cancel) begin
          n_if_done  = 1;
          e_if_rdata = mem_read(m_addr);
        end
        m_busy = 0;
      end
    end
    e_if_done = n_if_done;
    e_d_done  = n_d_done;
    e_mem_en  = m_busy && m_issue;
    e_busy    = m_busy;
  endtask

  // One clock cycle: drive the memory side, advance the model at the edge, then compare.
  task automatic applyStimulus();
    if (auto_mem) begin
      mem_ready = 1'b0;
      if (m_busy && m_issue) ready_cnt = next_lat;
      else if (m_busy) begin
        ready_cnt--;
        if (ready_cnt <= 0) begin
          if (if_cancel) ready_cnt = 1;
          else mem_ready = 1'b1;
        end
      end else if (stray_en && $urandom_range(0, 7) == 0) mem_ready = 1'b1;
      mem_rdata = (m_busy && mem_ready) ? mem_read(m_addr) : $urandom();
    end
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("mem_en", 32'(mem_en), 32'(e_mem_en));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("if_done", 32'(if_done), 32'(e_if_done));
    checkOutput("d_done", 32'(d_done), 32'(e_d_done));
    checkOutput("if_rdata", if_rdata, e_if_rdata);
    checkOutput("d_rdata", d_rdata, e_d_rdata);
    if (e_busy) checkOutput("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    if (e_mem_en) checkOutput("mem_we", 32'(mem_we), 32'(e_mem_we));
    if (e_mem_en && e_mem_we) checkOutput("mem_wdata", mem_wdata, e_mem_wdata);
  endtask

  task automatic resetDut();
    reset = 1'b1; if_req = 0; d_req = 0; if_cancel = 0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_req = 0; if_addr = '0; if_cancel = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    e_if_done = 0; e_d_done = 0; m_busy = 0; m_issue = 0;
    ready_cnt = 0; next_lat = 1; auto_mem = 1; stray_en = 0; if_drop = 0; d_drop = 0;
    mem_arr[30'h100000] = 32'h8C01_0004;
    mem_arr[30'h40]     = 32'h1234_5678;
    mem_arr[30'h200]    = 32'hCAFE_F00D;

    resetDut();
    checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_if_rdata", if_rdata, 32'd0);
    checkOutput("reset_d_rdata", d_rdata, 32'd0);

    // Simultaneous fetch and load, straight out of reset.
    if_req = 1; if_addr = 30'h200; d_req = 1; d_we = 0; d_addr = 30'h40; next_lat = 1;
    applyStimulus();
`ifdef MEM_ARB_RR_EN
    checkOutput("tie_first_addr", 32'(mem_addr), 32'h200);
`else
    checkOutput("tie_first_addr", 32'(mem_addr), 32'h40);
`endif
    applyStimulus();
    applyStimulus();
`ifdef MEM_ARB_RR_EN
    checkOutput("tie_first_done", 32'(if_done), 32'd1);
`else
    checkOutput("tie_first_done", 32'(d_done), 32'd1);
`endif
    applyStimulus();
    checkOutput("tie_second_en", 32'(mem_en), 32'd1);
`ifdef MEM_ARB_RR_EN
    checkOutput("tie_second_addr", 32'(mem_addr), 32'h40);
    if_req = 0;
`else
    checkOutput("tie_second_addr", 32'(mem_addr), 32'h200);
    d_req = 0;
`endif
    applyStimulus();
    applyStimulus();
`ifdef MEM_ARB_RR_EN
    checkOutput("tie_second_done", 32'(d_done), 32'd1);
`else
    checkOutput("tie_second_done", 32'(if_done), 32'd1);
`endif
    if_req = 0; d_req = 0;
    applyStimulus();

    // Single fetch with two-cycle memory latency.
    if_req = 1; if_addr = 30'h100000; next_lat = 2;
    applyStimulus();
    checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);
    checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h100000);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("fetch_done", 32'(if_done), 32'd1);
    checkOutput("fetch_rdata", if_rdata, 32'h8C01_0004);
    if_req = 0;
    applyStimulus();

    // Store leaves d_rdata alone.
    d_req = 1; d_we = 1; d_addr = 30'h10; d_wdata = 32'hDEAD_BEEF; next_lat = 3;
    applyStimulus();
    checkOutput("store_mem_we", 32'(mem_we), 32'd1);
    checkOutput("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    repeat (4) applyStimulus();
    checkOutput("store_done", 32'(d_done), 32'd1);
    checkOutput("store_d_rdata", d_rdata, 32'h1234_5678);
    d_req = 0; d_we = 0;
    applyStimulus();

    // Fetch cancelled one cycle after issue.
    if_req = 1; if_addr = 30'h300; next_lat = 2;
    applyStimulus();
    if_cancel = 1;
    applyStimulus();
    if_cancel = 0; if_req = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("cancel_if_done", 32'(if_done), 32'd0);
    checkOutput("cancel_if_rdata", if_rdata, 32'h8C01_0004);
    checkOutput("cancel_busy", 32'(busy), 32'd0);

    // Reset in WAIT, then a stale mem_ready.
    d_req = 1; d_we = 0; d_addr = 30'h5; next_lat = 3;
    applyStimulus();
    applyStimulus();
    reset = 1; d_req = 0;
    applyStimulus();
    reset = 0;
    applyStimulus();
    auto_mem = 0; mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
    applyStimulus();
    mem_ready = 0; auto_mem = 1;
    checkOutput("rstwait_d_done", 32'(d_done), 32'd0);
    checkOutput("rstwait_busy", 32'(busy), 32'd0);
    checkOutput("rstwait_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rstwait_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rstwait_d_rdata", d_rdata, 32'd0);
    checkOutput("rstwait_if_rdata", if_rdata, 32'd0);

    // Data request held through its done cycle is not re-granted there.
    d_req = 1; d_we = 0; d_addr = 30'h7; next_lat = 1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("hold_d_done", 32'(d_done), 32'd1);
    applyStimulus();
    checkOutput("hold_no_regrant", 32'(mem_en), 32'd0);
    d_req = 0;
    applyStimulus();

    // Random traffic on a small shared address range.
    stray_en = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_lat  = $urandom_range(1, 4);
      reset     = 0;
      if_cancel = 0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1; if_req = 0; d_req = 0; if_drop = 0; d_drop = 0;
      end else begin
        if (if_drop) begin if_req = 0; if_drop = 0; end
        if (if_req && e_if_done) if_drop = 1;
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = 30'($urandom_range(0, 15));
        end
        if ((if_req || (m_busy && !m_is_d)) && $urandom_range(0, 15) == 0) begin
          if_cancel = 1;
          if (if_req) if_drop = 1;
        end
        if (d_drop) begin d_req = 0; d_drop = 0; end
        if (d_req && e_d_done) d_drop = 1;
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = 30'($urandom_range(0, 15)); d_wdata = $urandom();
        end
      end
      applyStimulus();
    end

    reset = 0; if_req = 0; d_req = 0; if_cancel = 0; stray_en = 0;
    repeat (8) applyStimulus();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the instruction-fetch port and the MW-stage data port of the pipelined MIPS core. It runs a small FSM: arbitrate, issue one access, wait for the memory's completion, then return the result to the winning requester. It sits between the core's IF and MW stages and the unified memory. The core derives its fetch stall and MW stall from the `done` pulses.

## Interface
Parameters:
- `ADDR_W`, 30: word-address width; byte bits [1:0] are not carried.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; synchronous, active-high.
- `if_req`  in  1  fetch request; level, held until `if_done` or withdrawn by `if_cancel`.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_cancel`  in  1  one-cycle pulse; branch flush kills the fetch.
- `if_rdata`  out  DATA_W  fetched instruction; valid with `if_done`, holds its value until the next `if_done`.
- `if_done`  out  1  one-cycle completion pulse.
- `d_req`  in  1  data request; level, held until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; valid with `d_done`, holds its value until the next `d_done`.
- `d_done`  out  1  one-cycle completion pulse (loads and stores).
- `mem_en`  out  1  one-cycle issue strobe.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  registered address.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_rdata`  in  DATA_W  read data, sampled with `mem_ready`.
- `mem_ready`  in  1  completion pulse; never in the same cycle as `mem_en`.
- `busy`  out  1  high in ISSUE and WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Eligible ports are those with `req`=1 and their own `done`=0 this cycle. A port cannot be re-granted in its done cycle.
  - Fetch is also ineligible when `if_cancel`=1.
  - If any port is eligible: latch the winner's addr, we and wdata into the `mem_*` registers, record `grant` (I or D), clear `cancelled`, and go to ISSUE.
  - Loads and fetches register `mem_we`=0.
- **ISSUE**
  - `mem_en`=1 for exactly this cycle.
  - Go to WAIT unconditionally.
- **WAIT**
  - `mem_en`=0, and the `mem_*` registers hold their values.
  - When `mem_ready`=1:
    - grant D: capture `mem_rdata` into `d_rdata` on loads only (stores leave `d_rdata` unchanged), and pulse `d_done` next cycle.
    - grant I and `cancelled`=0: capture into `if_rdata` and pulse `if_done` next cycle.
    - grant I and `cancelled`=1: discard the data and pulse nothing.
  - In all three cases, go to IDLE.
- `if_cancel` in ISSUE or WAIT with grant I sets `cancelled`. The memory access still completes, because the memory cannot abort.
- `if_cancel` has no effect on a data transaction, or in IDLE beyond blocking the fetch grant that cycle.
- `mem_ready` outside WAIT is ignored.
- Priority when both ports are eligible: see Configuration.
- Reset values:
  - state IDLE
  - `mem_en`, `mem_we`, `if_done`, `d_done`, `busy` = 0
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0
  - `cancelled` = 0, `last_grant` = D
- Reset during ISSUE or WAIT abandons the transaction, and no done pulse is produced. A stale `mem_ready` arriving afterwards lands in IDLE and is ignored.

## Timing
- Request seen at edge of cycle 0:
  - cycle 1: ISSUE, `mem_en`=1.
  - earliest `mem_ready`: cycle 2.
  - `done`: cycle 3.
- Minimum request-to-done latency is 3 cycles. In general, `done` is 1 cycle after `mem_ready`.
- The done cycle is IDLE, so the next grant can occur in that cycle for the other port. Back-to-back transactions therefore have a 3-cycle minimum period.
- `busy`, `mem_en` and `done` are all registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin tie-break. When both ports are eligible, the port not in `last_grant` wins. `last_grant` updates on every grant and resets to D, so the first tie goes to fetch.
- `MEM_ARB_RR_EN` undefined: fixed priority; data always wins ties, since it is the older instruction. `last_grant` is not implemented.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x100000, memory returns 0x8C010004 two cycles after `mem_en` -> `mem_en` in cycle 1, `mem_addr`=0x100000, `if_done` in cycle 4, `if_rdata`=0x8C010004.
- **Simultaneous requests:** `if_req` and `d_req` (load 0x40) both rise in cycle 0.
  - Without the macro: data is served first, then fetch is issued in `d_done`'s cycle.
  - With the macro: fetch is served first, then data.
- **Store:** `d_we`=1, `d_addr`=0x10, `d_wdata`=0xDEADBEEF -> `mem_we`=1 and `mem_wdata`=0xDEADBEEF during `mem_en`; `d_done` pulses; `d_rdata` is unchanged.
- **Cancel in WAIT:** `if_cancel` pulses one cycle after `mem_en` of a fetch -> `mem_ready` arrives, no `if_done` is produced, `if_rdata` keeps its old value, and the FSM returns to IDLE.
- **Reset in WAIT:** assert `reset` in WAIT, then drive `mem_ready` the cycle after release -> no done pulse, all outputs 0, FSM in IDLE.
- **No re-grant in done cycle:** hold `d_req` high through the `d_done` cycle with `if_req`=0 -> no new `mem_en` is issued for the data port in that cycle.
